// File: rtl/fetch_stage_pkg.sv
// Shared widths, reset default and the {pc, ir} entry carried through the fetch buffer.
package fetch_stage_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction buffer between the memory response and IF/ID; flush wins over push/pop.
module fetch_buffer
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  fetch_entry_t       i_data,
  input  logic               i_pop,
  input  logic               i_flush,
  output fetch_entry_t       o_head,
  output logic               o_empty,
  output logic [CNT_W-1:0]   o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_push = i_push & ~i_flush;
  assign w_pop  = i_pop & ~i_flush & (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generation, in-order memory handshake with redirect discard, buffered IF output.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                id_ready,
  output logic                if_valid,
  output logic [INSTR_W-1:0]  if_ir,
  output logic [XLEN-1:0]     if_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_resp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_discard;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_inflight;
  logic             w_empty;
  logic             w_grant;
  logic             w_rsp;
  logic             w_push;
  logic             w_pop;
  logic [XLEN-1:0]  w_redirect_pc;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_entry;

  // Request throttle uses only registered occupancy so the grant path never sees the response path.
  assign w_inflight    = (CNT_W + 1)'(w_count) + (CNT_W + 1)'(r_outstanding);
  assign imem_req      = rst_n & ~redirect_valid & (w_inflight < (CNT_W + 1)'(DEPTH));
  assign imem_addr     = r_fetch_pc;
  assign w_grant       = imem_req & imem_gnt;
  assign w_rsp         = imem_rvalid & (r_outstanding != '0);
  assign w_push        = w_rsp & (r_discard == '0) & ~redirect_valid;
  assign w_pop         = ~w_empty & id_ready & ~redirect_valid;
  assign w_redirect_pc = redirect_pc & ~XLEN'(3);

  assign w_push_entry.pc = r_resp_pc;
  assign w_push_entry.ir = imem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the old path and must be dropped on return.
      r_fetch_pc    <= w_redirect_pc;
      r_resp_pc     <= w_redirect_pc;
      r_outstanding <= r_outstanding - CNT_W'(w_rsp);
      r_discard     <= r_outstanding - CNT_W'(w_rsp);
    end else begin
      if (w_grant) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      if (w_rsp) begin
        if (r_discard != '0) r_discard <= r_discard - CNT_W'(1);
        else                 r_resp_pc <= r_resp_pc + XLEN'(4);
      end
      r_outstanding <= r_outstanding + CNT_W'(w_grant) - CNT_W'(w_rsp);
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign if_valid = ~w_empty;
  assign if_ir    = w_head.ir;
  assign if_pc    = w_head.pc;

  a_rvalid_tracked: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order memory model and an expected-instruction scoreboard.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_pc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_ir          (if_ir),
    .if_pc          (if_pc)
  );

  typedef struct {
    logic [31:0] data;
    int          ready;
  } mem_t;

  mem_t         mem_q[$];
  fetch_entry_t sb[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           m_out, m_disc, m_buf;
  logic [31:0]  m_fetch;
  bit           gnt_rand;
  int           lat_min, lat_max;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  endtask

  // Evaluated at negedge: compare against the model, then advance the model to the next posedge.
  task automatic model_cycle();
    bit exp_req, g, r, p;
    mem_t m;
    fetch_entry_t e;
    exp_req = !redirect_valid && (m_buf + m_out < int'(DEPTH));
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("if_valid", 32'(if_valid), 32'(m_buf != 0));
    if (m_buf != 0 && sb.size() > 0) begin
      chk("if_pc", if_pc, sb[0].pc);
      chk("if_ir", if_ir, sb[0].ir);
    end
    g = exp_req && imem_gnt;
    r = imem_rvalid;
    p = (m_buf != 0) && id_ready && !redirect_valid;
    if (g) begin
      chk("imem_addr", imem_addr, m_fetch);
      m.data  = instr_of(imem_addr);
      m.ready = cyc + int'($urandom_range(lat_min, lat_max));
      mem_q.push_back(m);
    end
    if (r && mem_q.size() > 0) mem_q.delete(0);
    if (redirect_valid) begin
      sb.delete();
      m_buf   = 0;
      m_out   = m_out - int'(r);
      m_disc  = m_out;
      m_fetch = redirect_pc & ~32'h3;
    end else begin
      if (g) begin
        e.pc = m_fetch;
        e.ir = instr_of(m_fetch);
        sb.push_back(e);
        m_fetch = m_fetch + 32'd4;
      end
      if (r) begin
        if (m_disc > 0) m_disc--;
        else            m_buf++;
      end
      m_out = m_out + int'(g) - int'(r);
      if (p) begin
        sb.delete(0);
        m_buf--;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
  endtask

  task automatic reset_dut();
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_ir", if_ir, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, RPC);
    mem_q.delete();
    sb.delete();
    m_out = 0; m_disc = 0; m_buf = 0;
    m_fetch = RPC;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    drive_mem();
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b1;
    gnt_rand       = 1'b0;
    lat_min        = 1;
    lat_max        = 1;
    reset_dut();

    // Straight-line fetch with immediate grant and one-cycle memory.
    repeat (14) step();

    // Downstream stall then release.
    id_ready = 1'b0;
    repeat (5) step();
    id_ready = 1'b1;
    repeat (8) step();

    // Two requests in flight, redirect to an unaligned target.
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 20 && !(m_out == 2 && m_buf == 0); i++) step();
    chk("tmo_two_outstanding", 32'(m_out), 32'd2);
    redirect_to(32'h0000_0103);
    chk("redir_addr_aligned", imem_addr, 32'h0000_0100);
    chk("redir_if_valid_low", 32'(if_valid), 32'd0);
    lat_min = 1; lat_max = 1;
    repeat (12) step();

    // Redirect landing on a response and a pop in the same cycle.
    for (int i = 0; i < 20 && !(imem_rvalid && m_buf > 0); i++) step();
    chk("tmo_rvalid_pop", 32'(imem_rvalid && m_buf > 0), 32'd1);
    redirect_to(32'h0000_2000);
    chk("collide_if_valid_low", 32'(if_valid), 32'd0);
    repeat (10) step();

    // Back-to-back redirects with slow responses still in flight.
    lat_min = 3; lat_max = 3;
    repeat (4) step();
    redirect_to(32'h0000_0400);
    redirect_to(32'h0000_0800);
    chk("b2b_addr", imem_addr, 32'h0000_0800);
    repeat (14) step();

    // Address wrap at the top of the space.
    lat_min = 1; lat_max = 1;
    redirect_to(32'hFFFF_FFF8);
    chk("wrap_first_addr", imem_addr, 32'hFFFF_FFF8);
    repeat (10) step();

    // Reset with a full buffer, then random handshake timing.
    gnt_rand = 1'b1;
    lat_min = 1; lat_max = 3;
    id_ready = 1'b0;
    for (int i = 0; i < 40 && m_buf != 2; i++) step();
    chk("tmo_buffer_full", 32'(m_buf), 32'd2);
    id_ready = 1'b1;
    reset_dut();
    for (int i = 0; i < 80; i++) begin
      id_ready = 1'($urandom_range(0, 1));
      step();
    end
    id_ready = 1'b1;
    gnt_rand = 1'b0;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address after reset.
REQ-002 Parameter: DEPTH, 2, instruction buffer entries and maximum in-flight plus buffered fetches.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch address, word aligned.
REQ-007 imem_gnt  input  1  request accepted this cycle when high with imem_req.
REQ-008 imem_rvalid  input  1  response valid; responses return in request order, at least 1 cycle after grant.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 redirect_valid  input  1  branch/jump redirect from later stage.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 id_ready  input  1  downstream IF/ID register enable; low = stall.
REQ-013 if_valid  output  1  if_ir/if_pc hold a valid instruction.
REQ-014 if_ir  output  32  instruction to IF/ID register.
REQ-015 if_pc  output  32  address of if_ir.

Function
REQ-016 State: fetch_pc, resp_pc, outstanding count (0..DEPTH), discard count (0..outstanding), DEPTH-entry FIFO of {pc, ir}.
REQ-017 imem_req high iff not redirect_valid and (FIFO occupancy + outstanding) < DEPTH, using registered values only; imem_addr = fetch_pc.
REQ-018 imem_req & imem_gnt: fetch_pc <= fetch_pc + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), outstanding +1.
REQ-019 imem_rvalid with discard count > 0: drop data, discard -1, outstanding -1.
REQ-020 imem_rvalid with discard count = 0: push {resp_pc, imem_rdata}, resp_pc <= resp_pc + 4, outstanding -1.
REQ-021 Grant and rvalid same cycle: outstanding unchanged.
REQ-022 if_valid = FIFO non-empty; if_ir/if_pc = FIFO head; no bypass, rvalid in cycle N gives if_valid earliest in N+1.
REQ-023 Pop when if_valid & id_ready; push and pop same cycle allowed at any occupancy.
REQ-024 id_ready low: head and if_valid held stable.
REQ-025 redirect_valid: fetch_pc and resp_pc <= {redirect_pc[31:2], 2'b00}; FIFO flushed; discard <= outstanding - imem_rvalid; outstanding <= outstanding - imem_rvalid; any response that cycle dropped; no request issued that cycle.
REQ-026 Redirect overrides simultaneous pop and push; if_valid low the cycle after a redirect.
REQ-027 Back-to-back redirects: latest target wins; discard accounting stays exact.
REQ-028 FIFO overflow and outstanding overflow structurally impossible via REQ-017; imem_rvalid with outstanding = 0 is a protocol error (assertion, no state change).

Reset
REQ-029 rst_n low: immediately fetch_pc = resp_pc = RESET_PC, outstanding = 0, discard = 0, FIFO empty, imem_req = 0, if_valid = 0, if_ir = 0, if_pc = 0.
REQ-030 Deassertion: first request issued in the first clock edge's cycle after rst_n high, address RESET_PC.
REQ-031 Reset mid-operation: in-flight responses arriving after reset are not tracked; the memory model is reset together with the block.

Structure
REQ-032 Shared package: XLEN = 32, INSTR_W = 32, RESET_PC default, fetch entry struct {pc, ir}.
REQ-033 One sub-module: fetch_buffer (parameterised DEPTH FIFO, push/pop/flush, empty/count outputs); fetch_stage holds PC, counters, handshake.

Verification
REQ-034 Reset, gnt=1, 1-cycle response, id_ready=1 -> imem_addr 0,4,8...; if_pc 0,4,8 consecutive with matching if_ir; no bubbles after fill.
REQ-035 id_ready=0 for 5 cycles with instructions flowing -> at most 2 requests outstanding+buffered, if_pc/if_ir held, no loss or duplication on release.
REQ-036 Two requests outstanding, redirect to 32'h0000_0103 -> both responses dropped, next imem_addr 32'h0000_0100, next if_pc 32'h0000_0100.
REQ-037 Redirect coinciding with rvalid and pop -> that response dropped, if_valid low next cycle, first valid if_pc = target.
REQ-038 Redirect to 32'hFFFF_FFF8, continuous fetch -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 rst_n asserted mid-stream with 2 buffered -> outputs zero immediately, restart at RESET_PC, random gnt/rvalid latency yields in-order PCs.
